// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Multicycle control FSM for the 19-bit CPU. Sequences FETCH,
//            DECODE, EXEC, MEM and WB with memory/ALU handshakes, a return
//            stack for CALL/RET, wait-state timeouts and a sticky error trap.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int OPCODE_W = 5,
    parameter int FLAG_W   = 4,
    parameter int ZF_BIT   = 0,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FLAG_W-1:0]   flags_i,
    input  logic                im_ready_i,
    input  logic                dm_ready_i,
    input  logic                alu_done_i,
    input  logic                stack_full_i,
    input  logic                stack_empty_i,
    output logic                load_reg_o,
    output logic                inc_pc_o,
    output logic                load_pc_o,
    output logic [2:0]          load_select_o,
    output logic                rd_en_im_o,
    output logic                rd_en_dm_o,
    output logic                wr_en_dm_o,
    output logic                mode_o,
    output logic                alu_start_o,
    output logic                push_o,
    output logic                pop_o,
    output logic                halted_o,
    output logic                bus_err_o,
    output logic [2:0]          err_code_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Opcode class latched in DECODE; later states never look at live OPCODE.
    typedef enum logic [2:0] {
        C_ARITH  = 3'd0,
        C_MULDIV = 3'd1,
        C_NOT    = 3'd2,
        C_LOGIC  = 3'd3,
        C_LD     = 3'd4,
        C_ST     = 3'd5
    } cls_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_IM      = 3'd2;
    localparam logic [2:0] ERR_DM      = 3'd3;
    localparam logic [2:0] ERR_OVF     = 3'd4;
    localparam logic [2:0] ERR_UNF     = 3'd5;

    localparam logic [2:0] SEL_IR = 3'd0;
    localparam logic [2:0] SEL_A  = 3'd1;
    localparam logic [2:0] SEL_B  = 3'd2;
    localparam logic [2:0] SEL_C  = 3'd3;
    localparam logic [2:0] SEL_PC = 3'd4;

    // Shared opcode map of the 19-bit CPU
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_DEC  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(16);
    localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(17);

    // Counter only ever needs to reach WAIT_MAX-1
    localparam int CNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [2:0]       err_q, err_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             started_q, started_d;

    logic w_timeout;
    logic w_zf;
    logic w_mode;
    logic unused_flags;

    assign w_timeout    = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);
    assign w_zf         = flags_i[ZF_BIT];
    assign w_mode       = (cls_q == C_NOT) || (cls_q == C_LOGIC);
    assign unused_flags = ^flags_i;

    assign state_o    = state_q;
    assign err_code_o = err_q;

    // State and context registers; reset overrides every state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RESET;
            cls_q     <= C_ARITH;
            err_q     <= ERR_NONE;
            wait_q    <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            started_q <= started_d;
        end
    end

    // Next-state and strobe decode; wait counter falls back to 0 on any exit
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        err_d         = err_q;
        wait_d        = '0;
        started_d     = 1'b0;
        load_reg_o    = 1'b0;
        inc_pc_o      = 1'b0;
        load_pc_o     = 1'b0;
        load_select_o = SEL_IR;
        rd_en_im_o    = 1'b0;
        rd_en_dm_o    = 1'b0;
        wr_en_dm_o    = 1'b0;
        mode_o        = 1'b0;
        alu_start_o   = 1'b0;
        push_o        = 1'b0;
        pop_o         = 1'b0;
        halted_o      = 1'b0;
        bus_err_o     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                rd_en_im_o = 1'b1;
                if (im_ready_i) begin
                    load_reg_o    = 1'b1;
                    load_select_o = SEL_IR;
                    inc_pc_o      = 1'b1;
                    state_d       = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_IM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                        cls_d   = C_ARITH;
                        state_d = S_EXEC;
                    end
                    OP_MUL, OP_DIV: begin
                        cls_d   = C_MULDIV;
                        state_d = S_EXEC;
                    end
                    OP_NOT: begin
                        cls_d   = C_NOT;
                        state_d = S_EXEC;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        cls_d   = C_LOGIC;
                        state_d = S_EXEC;
                    end
                    OP_JMP: begin
                        load_pc_o     = 1'b1;
                        load_select_o = SEL_PC;
                        state_d       = S_FETCH;
                    end
                    OP_BEQ, OP_BNE: begin
                        if (w_zf == (opcode_i == OP_BEQ)) begin
                            load_pc_o     = 1'b1;
                            load_select_o = SEL_PC;
                        end
                        state_d = S_FETCH;
                    end
                    OP_CALL: begin
                        if (stack_full_i) begin
                            state_d = S_ERROR;
                            err_d   = ERR_OVF;
                        end else begin
                            push_o        = 1'b1;
                            load_pc_o     = 1'b1;
                            load_select_o = SEL_PC;
                            state_d       = S_FETCH;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty_i) begin
                            state_d = S_ERROR;
                            err_d   = ERR_UNF;
                        end else begin
                            pop_o         = 1'b1;
                            load_pc_o     = 1'b1;
                            load_select_o = SEL_PC;
                            state_d       = S_FETCH;
                        end
                    end
                    OP_LD: begin
                        cls_d   = C_LD;
                        state_d = S_MEM;
                    end
                    OP_ST: begin
                        cls_d   = C_ST;
                        state_d = S_MEM;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: begin
                        state_d = S_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end

            S_EXEC: begin
                // started_q marks that the ALU has already been kicked off
                mode_o      = w_mode;
                alu_start_o = !started_q;
                started_d   = 1'b1;
                if ((cls_q != C_MULDIV) || alu_done_i) begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                mode_o     = w_mode;
                load_reg_o = 1'b1;
                case (cls_q)
                    C_NOT, C_MULDIV: load_select_o = SEL_A;
                    C_LOGIC:         load_select_o = SEL_B;
                    default:         load_select_o = SEL_C;
                endcase
                state_d = S_FETCH;
            end

            S_MEM: begin
                if (cls_q == C_LD) begin
                    rd_en_dm_o = 1'b1;
                end else begin
                    wr_en_dm_o = 1'b1;
                end
                if (dm_ready_i) begin
                    if (cls_q == C_LD) begin
                        load_reg_o    = 1'b1;
                        load_select_o = SEL_A;
                    end
                    state_d = S_FETCH;
                end else if (w_timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_DM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_HALT:  halted_o  = 1'b1;

            S_ERROR: bus_err_o = 1'b1;

            default: state_d = S_RESET;
        endcase
    end

endmodule
`default_nettype wire
